// File: rtl/reg_file_sb_pkg.sv
// Shared constants, address type and popcount helper for the register file slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro used by this slice: REGFILE_BYPASS_EN (write-through forwarding).
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  // popcount operates on a fixed-width vector; callers zero-pad narrower vectors.
  localparam int NREGS_MAX = 64;
  localparam int PCW       = $clog2(NREGS_MAX) + 1;

  typedef logic [AW_DEF-1:0] reg_addr_t;

  function automatic logic [PCW-1:0] popcount(input logic [NREGS_MAX-1:0] v);
    logic [PCW-1:0] n;
    n = '0;
    for (int i = 0; i < NREGS_MAX; i++) begin
      n = n + {{(PCW-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Register file bus: read ports, writeback port, issue reservation and flush.
// Latency: reads and iss_ready are combinational; npend is registered.
// Backpressure: issue side only, via iss_ready; reads and writes are never stalled.
// Ports (master = core pipeline, slave = register file):
//   raddr/rdata/rbusy  NRD read ports        wr_en/waddr/wdata/wr_rel  writeback
//   iss_valid/iss_rd/iss_ready  reservation  flush  drop reservations   npend  pending count
interface reg_file_sb_if
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF,
  parameter int NRD  = 2
);
  logic [NRD-1:0][AW-1:0]   raddr;
  logic [NRD-1:0][XLEN-1:0] rdata;
  logic [NRD-1:0]           rbusy;
  logic                     wr_en;
  logic [AW-1:0]            waddr;
  logic [XLEN-1:0]          wdata;
  logic                     wr_rel;
  logic                     iss_valid;
  logic [AW-1:0]            iss_rd;
  logic                     iss_ready;
  logic                     flush;
  logic [AW:0]              npend;

  modport master (
    output raddr, wr_en, waddr, wdata, wr_rel, iss_valid, iss_rd, flush,
    input  rdata, rbusy, iss_ready, npend
  );

  modport slave (
    input  raddr, wr_en, waddr, wdata, wr_rel, iss_valid, iss_rd, flush,
    output rdata, rbusy, iss_ready, npend
  );
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, issue acceptance, flush, pending count.
// Latency: iss_ready combinational; busy and npend update at the next posedge.
// Backpressure: iss_ready low refuses an issue to a register that already has a pending result.
// Ports: clk, reset (sync, active-low); iss_valid/iss_rd/iss_ready; wr_en/wr_rel/waddr release;
//        flush; busy vector and npend outputs. REGFILE_BYPASS_EN lets a same-cycle release
//        satisfy iss_ready.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  input  logic             wr_en,
  input  logic             wr_rel,
  input  logic [AW-1:0]    waddr,
  input  logic             flush,
  output logic [NREGS-1:0] busy,
  output logic             iss_ready,
  output logic [AW:0]      npend
);

  logic                 rel_hit;
  logic                 iss_take;
  logic [NREGS-1:0]     busy_nxt;
  logic [NREGS_MAX-1:0] busy_pad;
  logic [AW:0]          npend_nxt;

  assign rel_hit  = wr_en && wr_rel && (waddr != '0);
  assign iss_take = iss_valid && iss_ready && (iss_rd != '0);

  always_comb begin
    iss_ready = !busy[iss_rd] || (iss_rd == '0);
`ifdef REGFILE_BYPASS_EN
    // The writeback releasing iss_rd in this cycle frees it for immediate reuse.
    if (rel_hit && (waddr == iss_rd)) iss_ready = 1'b1;
`endif
  end

  // Release first, then set, so a forwarded release-and-reissue leaves the bit set.
  // Flush overrides both, including an issue accepted in the same cycle.
  always_comb begin
    busy_nxt = busy;
    if (rel_hit)  busy_nxt[waddr]  = 1'b0;
    if (iss_take) busy_nxt[iss_rd] = 1'b1;
    if (flush)    busy_nxt         = '0;
  end

  always_comb begin
    busy_pad              = '0;
    busy_pad[NREGS-1:0]   = busy_nxt;
    npend_nxt             = (AW+1)'(popcount(busy_pad));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy  <= '0;
      npend <= '0;
    end else begin
      busy  <= busy_nxt;
      npend <= npend_nxt;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with NRD async read ports, one sync write port and a pending-write scoreboard.
// Latency: reads combinational, write lands at posedge, npend registered (1 cycle).
// Backpressure: only the issue reservation can be refused (iss_ready); r0 is hardwired to zero.
// Ports: clk, reset (sync, active-low), bus (reg_file_sb_if.slave).
// Build option REGFILE_BYPASS_EN: a same-cycle write is forwarded to matching read ports.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2
) (
  input logic        clk,
  input logic        reset,
  reg_file_sb_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]          regs [NREGS];
  logic [NREGS-1:0]         busy;
  logic [NRD-1:0][XLEN-1:0] rdata_d;
  logic [NRD-1:0]           rbusy_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (bus.wr_en && (bus.waddr != '0)) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  always_comb begin
    rdata_d = '0;
    rbusy_d = '0;
    for (int p = 0; p < NRD; p++) begin
      rdata_d[p] = regs[bus.raddr[p]];
      rbusy_d[p] = busy[bus.raddr[p]];
`ifdef REGFILE_BYPASS_EN
      if (bus.wr_en && (bus.waddr == bus.raddr[p])) begin
        rdata_d[p] = bus.wdata;
        if (bus.wr_rel) rbusy_d[p] = 1'b0;
      end
`endif
      // r0 overrides any forwarding; dropped writes to r0 must not leak through.
      if (bus.raddr[p] == '0) begin
        rdata_d[p] = '0;
        rbusy_d[p] = 1'b0;
      end
    end
  end

  assign bus.rdata = rdata_d;
  assign bus.rbusy = rbusy_d;

  rf_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (bus.iss_valid),
    .iss_rd    (bus.iss_rd),
    .wr_en     (bus.wr_en),
    .wr_rel    (bus.wr_rel),
    .waddr     (bus.waddr),
    .flush     (bus.flush),
    .busy      (busy),
    .iss_ready (bus.iss_ready),
    .npend     (bus.npend)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb (NRD=4): directed table, hand sequences, random vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_reg_file_sb;
  import regfile_pkg::*;

  localparam int NRD = 4;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_file_sb_if #(.XLEN(32), .AW(5), .NRD(NRD)) bus ();

  reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(NRD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: architectural register values and pending flags.
  logic [31:0] mreg  [32];
  bit          mbusy [32];

  typedef struct {
    reg_addr_t   ra0;
    logic        we;
    reg_addr_t   wa;
    logic [31:0] wd;
    logic        rel;
    logic        iv;
    reg_addr_t   ird;
    logic        fl;
    logic [31:0] e_rd;
    logic        e_rb;
    logic        e_rdy;
    int          e_np;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    for (int p = 0; p < NRD; p++) bus.raddr[p] = '0;
    bus.wr_en = 0; bus.waddr = '0; bus.wdata = '0; bus.wr_rel = 0;
    bus.iss_valid = 0; bus.iss_rd = '0; bus.flush = 0;
  endtask

  function automatic bit m_ready();
    if (bus.iss_rd == 0) return 1'b1;
    if (!mbusy[bus.iss_rd]) return 1'b1;
    return BYP && bus.wr_en && bus.wr_rel && (bus.waddr == bus.iss_rd);
  endfunction

  function automatic int m_npend();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(mbusy[i]);
    return n;
  endfunction

  // Compares combinational outputs against the model for the currently driven inputs.
  task automatic comb_check(input string tag);
    logic [31:0] ed;
    bit          eb;
    for (int p = 0; p < NRD; p++) begin
      if (bus.raddr[p] == 0) begin
        ed = 0; eb = 0;
      end else if (BYP && bus.wr_en && bus.waddr == bus.raddr[p]) begin
        ed = bus.wdata;
        eb = bus.wr_rel ? 1'b0 : mbusy[bus.raddr[p]];
      end else begin
        ed = mreg[bus.raddr[p]];
        eb = mbusy[bus.raddr[p]];
      end
      chk($sformatf("%s rdata[%0d]", tag, p), 64'(bus.rdata[p]), 64'(ed));
      chk($sformatf("%s rbusy[%0d]", tag, p), 64'(bus.rbusy[p]), 64'(eb));
    end
    chk($sformatf("%s iss_ready", tag), 64'(bus.iss_ready), 64'(m_ready()));
  endtask

  // Clocks one edge, advances the model and checks the registered pending count.
  task automatic tick(input string tag);
    bit acc;
    acc = bus.iss_valid && m_ready() && (bus.iss_rd != 0);
    @(posedge clk);
    #1;
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin mreg[i] = 0; mbusy[i] = 0; end
    end else begin
      if (bus.wr_en && bus.waddr != 0) mreg[bus.waddr] = bus.wdata;
      if (bus.wr_en && bus.wr_rel && bus.waddr != 0) mbusy[bus.waddr] = 0;
      if (acc) mbusy[bus.iss_rd] = 1;
      if (bus.flush) for (int i = 0; i < 32; i++) mbusy[i] = 0;
    end
    chk($sformatf("%s npend", tag), 64'(bus.npend), 64'(m_npend()));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin mreg[i] = 0; mbusy[i] = 0; end
    idle();
    reset = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1;
    #1;
    chk("rst npend", 64'(bus.npend), 64'd0);
    chk("rst rbusy", 64'(bus.rbusy), 64'd0);
    chk("rst iss_ready", 64'(bus.iss_ready), 64'd1);

    // Reset clears stored data and pending state.
    bus.wr_en = 1; bus.waddr = 5; bus.wdata = 32'hDEAD;
    bus.iss_valid = 1; bus.iss_rd = 6;
    #1; tick("t1 wr");
    idle();
    reset = 0;
    #1; tick("t1 rst");
    reset = 1;
    bus.raddr[0] = 5; bus.raddr[1] = 6;
    #1;
    chk("t1 r5", 64'(bus.rdata[0]), 64'd0);
    chk("t1 npend", 64'(bus.npend), 64'd0);
    chk("t1 rbusy", 64'(bus.rbusy), 64'd0);

    // Directed table: hazard, zero register, flush with concurrent issue.
    //            ra0 we wa wd             rel iv ird fl  e_rd                        e_rb      e_rdy e_np
    tbl[0]  = '{5'd7, 0, 5'd0, 32'h0,        0, 1, 5'd7, 0, 32'h0,                   1'b0,     1'b1, 1};
    tbl[1]  = '{5'd7, 0, 5'd0, 32'h0,        0, 1, 5'd7, 0, 32'h0,                   1'b1,     1'b0, 1};
    tbl[2]  = '{5'd7, 1, 5'd7, 32'h1234,     1, 0, 5'd0, 0, BYP ? 32'h1234 : 32'h0,  !BYP,     1'b1, 0};
    tbl[3]  = '{5'd7, 0, 5'd0, 32'h0,        0, 0, 5'd0, 0, 32'h1234,                1'b0,     1'b1, 0};
    tbl[4]  = '{5'd0, 1, 5'd0, 32'hFFFFFFFF, 0, 1, 5'd0, 0, 32'h0,                   1'b0,     1'b1, 0};
    tbl[5]  = '{5'd0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 0, 32'h0,                   1'b0,     1'b1, 0};
    tbl[6]  = '{5'd1, 0, 5'd0, 32'h0,        0, 1, 5'd1, 0, 32'h0,                   1'b0,     1'b1, 1};
    tbl[7]  = '{5'd0, 0, 5'd0, 32'h0,        0, 1, 5'd2, 0, 32'h0,                   1'b0,     1'b1, 2};
    tbl[8]  = '{5'd1, 0, 5'd0, 32'h0,        0, 1, 5'd4, 0, 32'h0,                   1'b1,     1'b1, 3};
    tbl[9]  = '{5'd0, 0, 5'd0, 32'h0,        0, 1, 5'd9, 1, 32'h0,                   1'b0,     1'b1, 0};
    tbl[10] = '{5'd9, 0, 5'd0, 32'h0,        0, 0, 5'd9, 0, 32'h0,                   1'b0,     1'b1, 0};
    tbl[11] = '{5'd5, 1, 5'd5, 32'hDEAD,     0, 1, 5'd3, 0, BYP ? 32'hDEAD : 32'h0,  1'b0,     1'b1, 1};

    for (int i = 0; i < 12; i++) begin
      idle();
      bus.raddr[0] = tbl[i].ra0;
      bus.wr_en = tbl[i].we; bus.waddr = tbl[i].wa; bus.wdata = tbl[i].wd; bus.wr_rel = tbl[i].rel;
      bus.iss_valid = tbl[i].iv; bus.iss_rd = tbl[i].ird; bus.flush = tbl[i].fl;
      #1;
      chk($sformatf("tbl%0d rdata0", i), 64'(bus.rdata[0]), 64'(tbl[i].e_rd));
      chk($sformatf("tbl%0d rbusy0", i), 64'(bus.rbusy[0]), 64'(tbl[i].e_rb));
      chk($sformatf("tbl%0d iss_ready", i), 64'(bus.iss_ready), 64'(tbl[i].e_rdy));
      comb_check($sformatf("tbl%0d", i));
      tick($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d npend_tbl", i), 64'(bus.npend), 64'(tbl[i].e_np));
    end

    // r3 is pending: release it while reading it and re-issuing it in the same cycle.
    idle();
    bus.wr_en = 1; bus.waddr = 3; bus.wdata = 32'hABCD; bus.wr_rel = 1;
    bus.raddr[1] = 3; bus.iss_valid = 1; bus.iss_rd = 3;
    #1;
    chk("byp rdata1", 64'(bus.rdata[1]), BYP ? 64'hABCD : 64'h0);
    chk("byp rbusy1", 64'(bus.rbusy[1]), BYP ? 64'd0 : 64'd1);
    chk("byp iss_ready", 64'(bus.iss_ready), BYP ? 64'd1 : 64'd0);
    tick("byp");
    chk("byp npend_after", 64'(bus.npend), BYP ? 64'd1 : 64'd0);
    idle();
    bus.raddr[1] = 3;
    #1;
    chk("byp next rdata1", 64'(bus.rdata[1]), 64'hABCD);

    // All four read ports return distinct registers in one cycle.
    for (int r = 1; r <= 4; r++) begin
      idle();
      bus.wr_en = 1; bus.waddr = 5'(r); bus.wdata = 32'(r);
      #1; tick($sformatf("mp wr%0d", r));
    end
    idle();
    for (int p = 0; p < NRD; p++) bus.raddr[p] = 5'(p + 1);
    #1;
    for (int p = 0; p < NRD; p++)
      chk($sformatf("mp rdata[%0d]", p), 64'(bus.rdata[p]), 64'(p + 1));

    // Random traffic concentrated on a few registers so hazards are frequent.
    for (int c = 0; c < 600; c++) begin
      idle();
      reset = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
      for (int p = 0; p < NRD; p++)
        bus.raddr[p] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      bus.wr_en     = 1'($urandom_range(0, 1));
      bus.waddr     = 5'($urandom_range(0, 7));
      bus.wdata     = $urandom;
      bus.wr_rel    = 1'($urandom_range(0, 1));
      bus.iss_valid = 1'($urandom_range(0, 1));
      bus.iss_rd    = 5'($urandom_range(0, 7));
      bus.flush     = ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0;
      #1;
      comb_check("rnd");
      tick("rnd");
    end
    reset = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
